alt_vipcto131_is2vid_sync_generator: RTL

ALT_VIPCTO131_IS2VID_SYNC_GENERATOR -- requirements
Module: alt_vipcto131_IS2Vid_sync_generator

---
 rtl/alt_vipcto131_is2vid_sync_generator.sv | 124 ++++++++++++
 1 files changed

// File: rtl/alt_vipcto131_is2vid_sync_generator.sv
// Video timing generator: raster counters, registered syncs, data-valid, start-of-frame and pixel position.
// Optional macro IS2VID_SYNC_POL_RUNTIME_EN adds h_pol_in/v_pol_in to set sync polarity per frame.
module alt_vipcto131_is2vid_sync_generator #(
   parameter int   H_ACTIVE   = 1920,
   parameter int   H_FRONT    = 88,
   parameter int   H_SYNC     = 44,
   parameter int   H_BACK     = 148,
   parameter int   V_ACTIVE   = 1080,
   parameter int   V_FRONT    = 4,
   parameter int   V_SYNC     = 5,
   parameter int   V_BACK     = 36,
   parameter logic H_SYNC_POL = 1'b1,
   parameter logic V_SYNC_POL = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
`ifdef IS2VID_SYNC_POL_RUNTIME_EN
   input  logic        h_pol_in,
   input  logic        v_pol_in,
`endif
   output logic        h_sync,
   output logic        v_sync,
   output logic        datavalid,
   output logic        sof,
   output logic [11:0] pixel_x,
   output logic [11:0] pixel_y
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   if (H_TOTAL < 2 || H_TOTAL > 4096 || H_ACTIVE < 1 || H_FRONT < 0 || H_SYNC < 0 || H_BACK < 0) begin : g_bad_h
      $error("alt_vipcto131_is2vid_sync_generator: illegal horizontal timing widths");
   end
   if (V_TOTAL < 2 || V_TOTAL > 4096 || V_ACTIVE < 1 || V_FRONT < 0 || V_SYNC < 0 || V_BACK < 0) begin : g_bad_v
      $error("alt_vipcto131_is2vid_sync_generator: illegal vertical timing widths");
   end

   // 13-bit boundaries so a sync end of exactly 4096 is still representable
   localparam logic [12:0] H_ACT_END  = 13'(H_ACTIVE);
   localparam logic [12:0] H_SYNC_BEG = 13'(H_ACTIVE + H_FRONT);
   localparam logic [12:0] H_SYNC_END = 13'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [12:0] H_LAST     = 13'(H_TOTAL - 1);
   localparam logic [12:0] V_ACT_END  = 13'(V_ACTIVE);
   localparam logic [12:0] V_SYNC_BEG = 13'(V_ACTIVE + V_FRONT);
   localparam logic [12:0] V_SYNC_END = 13'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [12:0] V_LAST     = 13'(V_TOTAL - 1);

   logic [11:0] h_cnt, v_cnt;
   logic [12:0] h_ext, v_ext;
   logic        at_origin, active, h_in_sync, v_in_sync;
   logic        h_pol, v_pol;

   assign h_ext     = {1'b0, h_cnt};
   assign v_ext     = {1'b0, v_cnt};
   assign at_origin = (h_cnt == '0) && (v_cnt == '0);
   assign active    = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
   assign h_in_sync = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
   assign v_in_sync = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);

   // Counters hold the position that the next enabled edge will present.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!enable) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_ext == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_ext == V_LAST) ? '0 : v_cnt + 12'd1;
      end else begin
         h_cnt <= h_cnt + 12'd1;
      end
   end

`ifdef IS2VID_SYNC_POL_RUNTIME_EN
   logic h_pol_q, v_pol_q;

   // New polarity is captured at the frame origin and applies from that edge on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_pol_q <= H_SYNC_POL;
         v_pol_q <= V_SYNC_POL;
      end else if (enable && at_origin) begin
         h_pol_q <= h_pol_in;
         v_pol_q <= v_pol_in;
      end
   end

   assign h_pol = (enable && at_origin) ? h_pol_in : h_pol_q;
   assign v_pol = (enable && at_origin) ? v_pol_in : v_pol_q;
`else
   assign h_pol = H_SYNC_POL;
   assign v_pol = V_SYNC_POL;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_sync    <= ~H_SYNC_POL;
         v_sync    <= ~V_SYNC_POL;
         datavalid <= 1'b0;
         sof       <= 1'b0;
         pixel_x   <= '0;
         pixel_y   <= '0;
      end else if (!enable) begin
         h_sync    <= ~H_SYNC_POL;
         v_sync    <= ~V_SYNC_POL;
         datavalid <= 1'b0;
         sof       <= 1'b0;
         pixel_x   <= '0;
         pixel_y   <= '0;
      end else begin
         h_sync    <= h_in_sync ? h_pol : ~h_pol;
         v_sync    <= v_in_sync ? v_pol : ~v_pol;
         datavalid <= active;
         sof       <= at_origin;
         pixel_x   <= active ? h_cnt : '0;
         pixel_y   <= active ? v_cnt : '0;
      end
   end

endmodule
